// File: rtl/memory_buffer_mb_if.sv
// Bus bundle for memory_buffer_mb: mode control, serial and parallel bank ports.
// Parity-error outputs exist only when BUF_PARITY_EN is defined.
interface memory_buffer_mb_if #(
    parameter int N_BUF  = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BSEL_W = $clog2(N_BUF);

    logic [1:0]              mode_req;
    logic                    mode_req_valid;
    logic                    mode_ack;
    logic                    mode_err;
    logic [1:0]              mode_cur;
    logic                    busy;

    logic                    s_w_en;
    logic [BSEL_W-1:0]       s_w_bank;
    logic [ADDR_W-1:0]       s_w_addr;
    logic [DATA_W-1:0]       s_w_data;
    logic                    s_r_en;
    logic [BSEL_W-1:0]       s_r_bank;
    logic [ADDR_W-1:0]       s_r_addr;
    logic                    s_r_valid;
    logic [DATA_W-1:0]       s_r_data;

    logic [N_BUF-1:0]        p_w_en;
    logic [N_BUF*ADDR_W-1:0] p_w_addr;
    logic [N_BUF*DATA_W-1:0] p_w_data;
    logic [N_BUF-1:0]        p_r_en;
    logic [N_BUF*ADDR_W-1:0] p_r_addr;
    logic [N_BUF-1:0]        p_r_valid;
    logic [N_BUF*DATA_W-1:0] p_r_data;
`ifdef BUF_PARITY_EN
    logic                    s_r_perr;
    logic [N_BUF-1:0]        p_r_perr;
`endif

    modport master (
        output mode_req, mode_req_valid,
        output s_w_en, s_w_bank, s_w_addr, s_w_data,
        output s_r_en, s_r_bank, s_r_addr,
        output p_w_en, p_w_addr, p_w_data, p_r_en, p_r_addr,
`ifdef BUF_PARITY_EN
        input  s_r_perr, p_r_perr,
`endif
        input  mode_ack, mode_err, mode_cur, busy,
        input  s_r_valid, s_r_data, p_r_valid, p_r_data
    );

    modport slave (
        input  mode_req, mode_req_valid,
        input  s_w_en, s_w_bank, s_w_addr, s_w_data,
        input  s_r_en, s_r_bank, s_r_addr,
        input  p_w_en, p_w_addr, p_w_data, p_r_en, p_r_addr,
`ifdef BUF_PARITY_EN
        output s_r_perr, p_r_perr,
`endif
        output mode_ack, mode_err, mode_cur, busy,
        output s_r_valid, s_r_data, p_r_valid, p_r_data
    );
endinterface

// File: rtl/memory_buffer_mb.sv
// Multi-bank buffer with serial/parallel/broadcast modes and drained mode switching.
// Optional even-parity storage and checking under `BUF_PARITY_EN.
module memory_buffer_mb #(
    parameter int N_BUF   = 8,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int OUT_REG = 0
) (
    input logic              clk,
    input logic              rst,
    memory_buffer_mb_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BSEL_W = $clog2(N_BUF);
`ifdef BUF_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SWITCH = 2'd2;

    localparam logic [1:0] M_SER = 2'd0;
    localparam logic [1:0] M_PAR = 2'd1;
    localparam logic [1:0] M_BC  = 2'd2;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    function automatic logic [MW-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef BUF_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [1:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] pend_q, pend_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       busy;
    logic       inflight;

    logic [MW-1:0] mem_q [N_BUF][DEPTH];

    logic [N_BUF-1:0]  we;
    logic [ADDR_W-1:0] wa [N_BUF];
    logic [DATA_W-1:0] wd [N_BUF];
    logic [ADDR_W-1:0] pra [N_BUF];
    logic [N_BUF-1:0]  pre;
    logic [MW-1:0]     p_word [N_BUF];
    logic              sre;
    logic [ADDR_W-1:0] saddr;
    logic [MW-1:0]     s_word;

    logic              s_v1_q;
    logic [MW-1:0]     s_w1_q;
    logic [N_BUF-1:0]  p_v1_q;
    logic [MW-1:0]     p_w1_q [N_BUF];

    logic              s_vo;
    logic [MW-1:0]     s_wo;
    logic [N_BUF-1:0]  p_vo;
    logic [MW-1:0]     p_wo [N_BUF];

    assign busy = (state_q != ST_IDLE);

    // Only a registered stage ahead of the outputs can still be in flight.
    assign inflight = (OUT_REG != 0) && (s_v1_q || (|p_v1_q));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (1'b1)
            (state_q == ST_IDLE): begin
                if (bus.mode_req_valid) begin
                    if (bus.mode_req == 2'd3) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        pend_d  = bus.mode_req;
                        state_d = ST_DRAIN;
                    end
                end
            end
            (state_q == ST_DRAIN): begin
                if (!inflight) state_d = ST_SWITCH;
            end
            (state_q == ST_SWITCH): begin
                mode_d  = pend_q;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we = '0;
        for (int i = 0; i < N_BUF; i++) begin
            wa[i] = bus.p_w_addr[i*ADDR_W +: ADDR_W];
            wd[i] = bus.p_w_data[i*DATA_W +: DATA_W];
            if (!busy) begin
                unique case (1'b1)
                    (mode_q == M_PAR): begin
                        we[i] = bus.p_w_en[i] && addr_ok(wa[i]);
                    end
                    (mode_q == M_BC): begin
                        we[i] = bus.s_w_en && addr_ok(bus.s_w_addr);
                        wa[i] = bus.s_w_addr;
                        wd[i] = bus.s_w_data;
                    end
                    default: begin
                        we[i] = bus.s_w_en && addr_ok(bus.s_w_addr)
                             && (bus.s_w_bank == BSEL_W'(i));
                        wa[i] = bus.s_w_addr;
                        wd[i] = bus.s_w_data;
                    end
                endcase
            end
        end
    end

    // Parallel reads, plus the serial/monitor read with parallel-address priority.
    always_comb begin
        sre    = !busy && bus.s_r_en;
        saddr  = bus.s_r_addr;
        s_word = '0;
        for (int i = 0; i < N_BUF; i++) begin
            pra[i]    = bus.p_r_addr[i*ADDR_W +: ADDR_W];
            pre[i]    = !busy && (mode_q == M_PAR) && bus.p_r_en[i];
            p_word[i] = addr_ok(pra[i]) ? mem_q[i][pra[i]] : '0;
            if (pre[i] && (bus.s_r_bank == BSEL_W'(i))) saddr = pra[i];
        end
        for (int i = 0; i < N_BUF; i++) begin
            if ((bus.s_r_bank == BSEL_W'(i)) && addr_ok(saddr))
                s_word = mem_q[i][saddr];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BUF; i++) begin
            if (we[i]) mem_q[i][wa[i]] <= enc(wd[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= M_SER;
            pend_q  <= M_SER;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            s_v1_q  <= 1'b0;
            s_w1_q  <= '0;
            p_v1_q  <= '0;
            for (int i = 0; i < N_BUF; i++) p_w1_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            s_v1_q  <= sre;
            if (sre) s_w1_q <= s_word;
            p_v1_q  <= pre;
            for (int i = 0; i < N_BUF; i++) begin
                if (pre[i]) p_w1_q[i] <= p_word[i];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic             s_v2_q;
        logic [MW-1:0]    s_w2_q;
        logic [N_BUF-1:0] p_v2_q;
        logic [MW-1:0]    p_w2_q [N_BUF];

        always_ff @(posedge clk) begin
            if (rst) begin
                s_v2_q <= 1'b0;
                s_w2_q <= '0;
                p_v2_q <= '0;
                for (int i = 0; i < N_BUF; i++) p_w2_q[i] <= '0;
            end else begin
                s_v2_q <= s_v1_q;
                if (s_v1_q) s_w2_q <= s_w1_q;
                p_v2_q <= p_v1_q;
                for (int i = 0; i < N_BUF; i++) begin
                    if (p_v1_q[i]) p_w2_q[i] <= p_w1_q[i];
                end
            end
        end

        assign s_vo = s_v2_q;
        assign s_wo = s_w2_q;
        assign p_vo = p_v2_q;
        assign p_wo = p_w2_q;
    end else begin : g_noreg
        assign s_vo = s_v1_q;
        assign s_wo = s_w1_q;
        assign p_vo = p_v1_q;
        assign p_wo = p_w1_q;
    end

    logic [N_BUF*DATA_W-1:0] p_data;
`ifdef BUF_PARITY_EN
    logic [N_BUF-1:0]        p_perr;
`endif

    always_comb begin
        p_data = '0;
`ifdef BUF_PARITY_EN
        p_perr = '0;
`endif
        for (int i = 0; i < N_BUF; i++) begin
            p_data[i*DATA_W +: DATA_W] = p_wo[i][DATA_W-1:0];
`ifdef BUF_PARITY_EN
            p_perr[i] = p_vo[i] && (^p_wo[i]);
`endif
        end
    end

    assign bus.mode_ack  = ack_q;
    assign bus.mode_err  = err_q;
    assign bus.mode_cur  = mode_q;
    assign bus.busy      = busy;
    assign bus.s_r_valid = s_vo;
    assign bus.s_r_data  = s_wo[DATA_W-1:0];
    assign bus.p_r_valid = p_vo;
    assign bus.p_r_data  = p_data;
`ifdef BUF_PARITY_EN
    assign bus.s_r_perr  = s_vo && (^s_wo);
    assign bus.p_r_perr  = p_perr;
`endif
endmodule

// File: tb/tb_memory_buffer_mb.sv
// Directed bench for memory_buffer_mb (N_BUF=4, DATA_W=16, DEPTH=48, OUT_REG=0).
// Inputs are driven 1 time unit after each rising edge and outputs sampled there.
module tb_memory_buffer_mb;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int D  = 48;
    localparam int AW = $clog2(D);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    memory_buffer_mb_if #(.N_BUF(N), .DATA_W(DW), .DEPTH(D)) bus ();

    memory_buffer_mb #(.N_BUF(N), .DATA_W(DW), .DEPTH(D), .OUT_REG(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        bus.mode_req       = 2'd0;
        bus.mode_req_valid = 1'b0;
        bus.s_w_en   = 1'b0;
        bus.s_w_bank = '0;
        bus.s_w_addr = '0;
        bus.s_w_data = '0;
        bus.s_r_en   = 1'b0;
        bus.s_r_bank = '0;
        bus.s_r_addr = '0;
        bus.p_w_en   = '0;
        bus.p_w_addr = '0;
        bus.p_w_data = '0;
        bus.p_r_en   = '0;
        bus.p_r_addr = '0;
    endtask

    task automatic s_write(input int bank, input int addr, input logic [15:0] d);
        bus.s_w_en   = 1'b1;
        bus.s_w_bank = 2'(bank);
        bus.s_w_addr = AW'(addr);
        bus.s_w_data = d;
    endtask

    task automatic s_read(input int bank, input int addr);
        bus.s_r_en   = 1'b1;
        bus.s_r_bank = 2'(bank);
        bus.s_r_addr = AW'(addr);
    endtask

    // Full switch: busy next cycle, ack within 3 cycles, enables ignored while busy.
    task automatic switch_mode(input logic [1:0] m);
        int n;
        bus.mode_req       = m;
        bus.mode_req_valid = 1'b1;
        tick();
        clr();
        chk("busy_after_req", 64'(bus.busy), 64'd1);
        s_read(0, 3);
        n = 1;
        while (!bus.mode_ack && n < 8) begin
            tick();
            n++;
        end
        clr();
        chk("ack_latency", 64'(n), 64'd3);
        chk("ack_seen", 64'(bus.mode_ack), 64'd1);
        chk("ack_err", 64'(bus.mode_err), 64'd0);
        chk("mode_cur_new", 64'(bus.mode_cur), 64'(m));
        chk("busy_clear", 64'(bus.busy), 64'd0);
        chk("busy_read_dropped", 64'(bus.s_r_valid), 64'd0);
    endtask

    initial begin
        int ack_seen;
        clr();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mode_cur", 64'(bus.mode_cur), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ack", 64'(bus.mode_ack), 64'd0);
        chk("rst_err", 64'(bus.mode_err), 64'd0);
        chk("rst_s_valid", 64'(bus.s_r_valid), 64'd0);
        chk("rst_p_valid", 64'(bus.p_r_valid), 64'd0);
        chk("rst_s_data", 64'(bus.s_r_data), 64'd0);

        // Serial write then read
        s_write(2, 7, 16'hA5A5);
        tick();
        clr();
        s_read(2, 7);
        tick();
        clr();
        chk("ser_valid", 64'(bus.s_r_valid), 64'd1);
        chk("ser_data", 64'(bus.s_r_data), 64'hA5A5);
        chk("ser_p_valid", 64'(bus.p_r_valid), 64'd0);
        tick();
        chk("ser_valid_pulse", 64'(bus.s_r_valid), 64'd0);
        chk("ser_data_hold", 64'(bus.s_r_data), 64'hA5A5);

        // Parallel mode
        switch_mode(2'd1);
        bus.p_w_en = 4'b1111;
        for (int i = 0; i < N; i++) begin
            bus.p_w_addr[i*AW +: AW] = AW'(3 + i);
            bus.p_w_data[i*DW +: DW] = 16'(16'h1000 + i);
        end
        tick();
        clr();
        bus.p_r_en = 4'b1111;
        for (int i = 0; i < N; i++) bus.p_r_addr[i*AW +: AW] = AW'(3 + i);
        tick();
        clr();
        chk("par_valid", 64'(bus.p_r_valid), 64'hF);
        chk("par_data", 64'(bus.p_r_data), 64'h1003_1002_1001_1000);
        chk("par_s_valid", 64'(bus.s_r_valid), 64'd0);

        // Serial write ignored; monitor read takes the parallel address
        s_write(0, 3, 16'hFFFF);
        tick();
        clr();
        s_read(0, 20);
        bus.p_r_en = 4'b0001;
        bus.p_r_addr[0 +: AW] = AW'(3);
        tick();
        clr();
        chk("mon_valid", 64'(bus.s_r_valid), 64'd1);
        chk("mon_data", 64'(bus.s_r_data), 64'h1000);
        chk("mon_p_valid", 64'(bus.p_r_valid), 64'h1);
        chk("mon_p_data0", 64'(bus.p_r_data[15:0]), 64'h1000);

        // Broadcast write, read back per bank in serial mode
        switch_mode(2'd2);
        s_write(0, 10, 16'hBEEF);
        tick();
        clr();
        switch_mode(2'd0);
        for (int b = 0; b < N; b++) begin
            s_read(b, 10);
            tick();
            clr();
            chk($sformatf("bcast_bank%0d", b), 64'(bus.s_r_data), 64'hBEEF);
            chk($sformatf("bcast_valid%0d", b), 64'(bus.s_r_valid), 64'd1);
        end

        // Read-before-write hazard
        s_write(1, 5, 16'h1111);
        tick();
        clr();
        s_write(1, 5, 16'h2222);
        s_read(1, 5);
        tick();
        clr();
        chk("rbw_old", 64'(bus.s_r_data), 64'h1111);
        s_read(1, 5);
        tick();
        clr();
        chk("rbw_new", 64'(bus.s_r_data), 64'h2222);

        // Invalid request from a non-zero mode
        switch_mode(2'd1);
        bus.mode_req       = 2'd3;
        bus.mode_req_valid = 1'b1;
        tick();
        clr();
        chk("bad_ack", 64'(bus.mode_ack), 64'd1);
        chk("bad_err", 64'(bus.mode_err), 64'd1);
        chk("bad_busy", 64'(bus.busy), 64'd0);
        chk("bad_mode_cur", 64'(bus.mode_cur), 64'd1);
        tick();
        chk("bad_ack_pulse", 64'(bus.mode_ack), 64'd0);
        chk("bad_busy_later", 64'(bus.busy), 64'd0);

        // Reset in DRAIN
        s_read(1, 5);
        bus.mode_req       = 2'd2;
        bus.mode_req_valid = 1'b1;
        tick();
        clr();
        chk("drain_busy", 64'(bus.busy), 64'd1);
        chk("drain_s_data", 64'(bus.s_r_data), 64'h2222);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mode", 64'(bus.mode_cur), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_s_valid", 64'(bus.s_r_valid), 64'd0);
        chk("mid_rst_p_valid", 64'(bus.p_r_valid), 64'd0);
        chk("mid_rst_s_data", 64'(bus.s_r_data), 64'd0);
        ack_seen = int'(bus.mode_ack);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.mode_ack) ack_seen = 1;
        end
        chk("mid_rst_no_ack", 64'(ack_seen), 64'd0);

        // Out-of-range address reads return valid zero
        s_read(3, 63);
        tick();
        clr();
        chk("oor_valid", 64'(bus.s_r_valid), 64'd1);
        chk("oor_data", 64'(bus.s_r_data), 64'd0);
        s_read(1, 5);
        tick();
        clr();
        chk("after_oor_data", 64'(bus.s_r_data), 64'h2222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
